// File: rtl/heap_array_allocator.sv
// heap_array_allocator
//   Arbitrates heap-array allocate/free requests from two requesters and owns
//   the array-handle resources: the LIFO stack of freed handles, the
//   high-water allocation counter, the allocated bitmap and the per-array
//   size table. Heap memory itself lives outside (addressed handle*NArea+index).
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset, clears all state
//   req_valid   per-requester request, held until matching ack
//   req_free    per-requester op: 0 allocate, 1 free
//   req_array   per-requester handle to free, requester r at [r*W +: W]
//   ack         one-cycle completion pulse per requester
//   ack_array   handle allocated or freed
//   ack_error   op rejected (valid with ack), no state change
//   len_valid   array-length update strobe
//   len_array   handle being written
//   len_index   element index written
//   size_array  size-query handle
//   size_out    size of size_array (0 when out of range)
//   in_use      number of currently allocated handles
//   allocs      number of handles ever minted
module heap_array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NArea              = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      req_valid,
  input  logic [1:0]                      req_free,
  input  logic [2*MemoryElementWidth-1:0] req_array,
  output logic [1:0]                      ack,
  output logic [MemoryElementWidth-1:0]   ack_array,
  output logic                            ack_error,
  input  logic                            len_valid,
  input  logic [MemoryElementWidth-1:0]   len_array,
  input  logic [MemoryElementWidth-1:0]   len_index,
  input  logic [MemoryElementWidth-1:0]   size_array,
  output logic [MemoryElementWidth-1:0]   size_out,
  output logic [MemoryElementWidth-1:0]   in_use,
  output logic [MemoryElementWidth-1:0]   allocs
);

  localparam int W = MemoryElementWidth;
  localparam logic [W-1:0] NARR  = W'(NArrays);
  localparam logic [W-1:0] NAREA = W'(NArea);
  localparam logic [W-1:0] ONE   = W'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 win_q, win_d;
  logic [W-1:0]         ack_array_q, ack_array_d;
  logic                 ack_error_q, ack_error_d;
  logic [W-1:0]         allocs_q, allocs_d;
  logic [W-1:0]         in_use_q, in_use_d;
  logic [W-1:0]         top_q, top_d;
  logic [W-1:0]         freed_q [NArrays];
  logic [W-1:0]         freed_d [NArrays];
  logic [NArrays-1:0]   bitmap_q, bitmap_d;
  logic [W-1:0]         sizes_q [NArrays];
  logic [W-1:0]         sizes_d [NArrays];

  logic                 go;
  logic                 win;
  logic                 op_free;
  logic [W-1:0]         op_arr;
  logic [W-1:0]         handle;
  logic                 got_handle;
  logic                 free_ok;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    ack_array_d = ack_array_q;
    ack_error_d = ack_error_q;
    allocs_d    = allocs_q;
    in_use_d    = in_use_q;
    top_d       = top_q;
    freed_d     = freed_q;
    bitmap_d    = bitmap_q;
    sizes_d     = sizes_q;
    go          = 1'b0;
    win         = 1'b0;
    handle      = '0;
    got_handle  = 1'b0;
    free_ok     = 1'b0;

    // Arbitration: a lone requester wins; a tie goes to the pointer.
    if (state_q == IDLE) begin
      unique case (req_valid)
        2'b01:   begin go = 1'b1; win = 1'b0; end
        2'b10:   begin go = 1'b1; win = 1'b1; end
        2'b11:   begin go = 1'b1; win = rr_q; end
        default: go = 1'b0;
      endcase
    end else begin
      state_d = IDLE;
    end

    op_free = win ? req_free[1] : req_free[0];
    op_arr  = win ? req_array[2*W-1:W] : req_array[W-1:0];

    // Length update is evaluated first so an allocation on the same
    // handle in the same edge overrides it with its clear to 0.
    if (len_valid && (len_index < NAREA)) begin
      for (int unsigned i = 0; i < NArrays; i++) begin
        if ((len_array == W'(i)) && bitmap_q[i] && (sizes_q[i] <= len_index))
          sizes_d[i] = len_index + ONE;
      end
    end

    if (go) begin
      state_d = ACK;
      win_d   = win;
      rr_d    = ~win;
      if (!op_free) begin
        if (top_q != '0) begin
          top_d      = top_q - ONE;
          got_handle = 1'b1;
          for (int unsigned i = 0; i < NArrays; i++)
            if (top_q - ONE == W'(i)) handle = freed_q[i];
        end else if (allocs_q < NARR) begin
          handle     = allocs_q;
          allocs_d   = allocs_q + ONE;
          got_handle = 1'b1;
        end
        if (got_handle) begin
          for (int unsigned i = 0; i < NArrays; i++) begin
            if (handle == W'(i)) begin
              bitmap_d[i] = 1'b1;
              sizes_d[i]  = '0;
            end
          end
          in_use_d    = in_use_q + ONE;
          ack_array_d = handle;
          ack_error_d = 1'b0;
        end else begin
          ack_array_d = '0;
          ack_error_d = 1'b1;
        end
      end else begin
        // Out-of-range handles never match, so they fall through as errors.
        for (int unsigned i = 0; i < NArrays; i++)
          if ((op_arr == W'(i)) && bitmap_q[i]) free_ok = 1'b1;
        ack_array_d = op_arr;
        ack_error_d = ~free_ok;
        if (free_ok) begin
          for (int unsigned i = 0; i < NArrays; i++) begin
            if (op_arr == W'(i)) bitmap_d[i] = 1'b0;
            if (top_q == W'(i))  freed_d[i]  = op_arr;
          end
          top_d    = top_q + ONE;
          in_use_d = in_use_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      win_q       <= 1'b0;
      ack_array_q <= '0;
      ack_error_q <= 1'b0;
      allocs_q    <= '0;
      in_use_q    <= '0;
      top_q       <= '0;
      bitmap_q    <= '0;
      for (int unsigned i = 0; i < NArrays; i++) begin
        freed_q[i] <= '0;
        sizes_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      ack_array_q <= ack_array_d;
      ack_error_q <= ack_error_d;
      allocs_q    <= allocs_d;
      in_use_q    <= in_use_d;
      top_q       <= top_d;
      bitmap_q    <= bitmap_d;
      freed_q     <= freed_d;
      sizes_q     <= sizes_d;
    end
  end

  always_comb begin
    size_out = '0;
    for (int unsigned i = 0; i < NArrays; i++)
      if (size_array == W'(i)) size_out = sizes_q[i];
  end

  assign ack       = (state_q == ACK) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign ack_array = ack_array_q;
  assign ack_error = ack_error_q;
  assign in_use    = in_use_q;
  assign allocs    = allocs_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
module tb_heap_array_allocator;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_free;
  logic [23:0] req_array;
  logic [1:0]  ack;
  logic [11:0] ack_array;
  logic        ack_error;
  logic        len_valid;
  logic [11:0] len_array;
  logic [11:0] len_index;
  logic [11:0] size_array;
  logic [11:0] size_out;
  logic [11:0] in_use;
  logic [11:0] allocs;

  int checks = 0;
  int errors = 0;

  heap_array_allocator #(
    .MemoryElementWidth(12),
    .NArrays(4),
    .NArea(2)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
    .ack(ack), .ack_array(ack_array), .ack_error(ack_error),
    .len_valid(len_valid), .len_array(len_array), .len_index(len_index),
    .size_array(size_array), .size_out(size_out),
    .in_use(in_use), .allocs(allocs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          r;
    logic        fr;
    logic [11:0] arr;
    logic [11:0] e_arr;
    logic        e_err;
    logic [11:0] e_allocs;
    logic [11:0] e_inuse;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; req_free = '0; req_array = '0;
    len_valid = 1'b0; len_array = '0; len_index = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Issue one op from requester r, wait (bounded) for its ack, drop the request.
  task automatic do_op(input int r, input logic fr, input logic [11:0] arr,
                       input string nm, output logic [11:0] aa, output logic ae);
    logic seen;
    logic [1:0] exp_ack;
    seen = 1'b0;
    exp_ack = (r == 1) ? 2'b10 : 2'b01;
    req_free[r] = fr;
    req_array[r*12 +: 12] = arr;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (ack != 2'b00) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s ack_timeout: got no ack expected ack", nm);
    end
    chk({nm, " ack_onehot"}, {30'd0, ack}, {30'd0, exp_ack});
    aa = ack_array;
    ae = ack_error;
    req_valid[r] = 1'b0;
    @(negedge clock);
    chk({nm, " ack_pulse"}, {30'd0, ack}, 32'd0);
  endtask

  task automatic len_upd(input logic [11:0] a, input logic [11:0] i);
    len_valid = 1'b1; len_array = a; len_index = i;
    @(negedge clock);
    len_valid = 1'b0;
  endtask

  logic [11:0] aa;
  logic        ae;
  int          n1, n2, cnt;
  logic [11:0] a1, a2;

  initial begin
    tbl[0]  = '{0, 1'b0, 12'd0, 12'd0, 1'b0, 12'd1, 12'd1};
    tbl[1]  = '{0, 1'b0, 12'd0, 12'd1, 1'b0, 12'd2, 12'd2};
    tbl[2]  = '{1, 1'b0, 12'd0, 12'd2, 1'b0, 12'd3, 12'd3};
    tbl[3]  = '{0, 1'b1, 12'd1, 12'd1, 1'b0, 12'd3, 12'd2};
    tbl[4]  = '{1, 1'b1, 12'd2, 12'd2, 1'b0, 12'd3, 12'd1};
    tbl[5]  = '{0, 1'b0, 12'd0, 12'd2, 1'b0, 12'd3, 12'd2};
    tbl[6]  = '{1, 1'b0, 12'd0, 12'd1, 1'b0, 12'd3, 12'd3};
    tbl[7]  = '{0, 1'b0, 12'd0, 12'd3, 1'b0, 12'd4, 12'd4};
    tbl[8]  = '{0, 1'b0, 12'd0, 12'd0, 1'b1, 12'd4, 12'd4};
    tbl[9]  = '{0, 1'b1, 12'd5, 12'd5, 1'b1, 12'd4, 12'd4};
    tbl[10] = '{1, 1'b1, 12'd3, 12'd3, 1'b0, 12'd4, 12'd3};
    tbl[11] = '{1, 1'b1, 12'd3, 12'd3, 1'b1, 12'd4, 12'd3};
    tbl[12] = '{0, 1'b0, 12'd0, 12'd3, 1'b0, 12'd4, 12'd4};

    size_array = '0;
    do_reset();

    // Reset state
    chk("rst ack", {30'd0, ack}, 32'd0);
    chk("rst ack_array", {20'd0, ack_array}, 32'd0);
    chk("rst ack_error", {31'd0, ack_error}, 32'd0);
    chk("rst allocs", {20'd0, allocs}, 32'd0);
    chk("rst in_use", {20'd0, in_use}, 32'd0);
    chk("rst size_out", {20'd0, size_out}, 32'd0);

    // Back-to-back allocates from req0 held high: acks two cycles apart
    n1 = -1; n2 = -1; a1 = '0; a2 = '0;
    req_free[0] = 1'b0; req_valid[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (ack[0]) begin
        if (n1 < 0) begin n1 = k; a1 = ack_array; end
        else begin n2 = k; a2 = ack_array; break; end
      end
    end
    req_valid[0] = 1'b0;
    chk("b2b first_seen", {31'd0, n1 > 0}, 32'd1);
    chk("b2b second_seen", {31'd0, n2 > 0}, 32'd1);
    chk("b2b spacing", n2 - n1, 32'd2);
    chk("b2b handle0", {20'd0, a1}, 32'd0);
    chk("b2b handle1", {20'd0, a2}, 32'd1);
    chk("b2b allocs", {20'd0, allocs}, 32'd2);
    chk("b2b in_use", {20'd0, in_use}, 32'd2);

    // Table: alloc, LIFO recycling, exhaustion, bad frees
    do_reset();
    for (int v = 0; v < 13; v++) begin
      do_op(tbl[v].r, tbl[v].fr, tbl[v].arr, $sformatf("vec%0d", v), aa, ae);
      chk($sformatf("vec%0d ack_array", v), {20'd0, aa}, {20'd0, tbl[v].e_arr});
      chk($sformatf("vec%0d ack_error", v), {31'd0, ae}, {31'd0, tbl[v].e_err});
      chk($sformatf("vec%0d allocs", v), {20'd0, allocs}, {20'd0, tbl[v].e_allocs});
      chk($sformatf("vec%0d in_use", v), {20'd0, in_use}, {20'd0, tbl[v].e_inuse});
    end

    // Length updates
    do_reset();
    do_op(0, 1'b0, 12'd0, "len alloc", aa, ae);
    chk("len alloc handle", {20'd0, aa}, 32'd0);
    size_array = 12'd0;
    len_upd(12'd0, 12'd0); #1 chk("len (0,0)", {20'd0, size_out}, 32'd1);
    len_upd(12'd0, 12'd1); #1 chk("len (0,1)", {20'd0, size_out}, 32'd2);
    len_upd(12'd0, 12'd0); #1 chk("len (0,0) no shrink", {20'd0, size_out}, 32'd2);
    len_upd(12'd0, 12'd2); #1 chk("len (0,2) out of area", {20'd0, size_out}, 32'd2);
    size_array = 12'd1;
    len_upd(12'd1, 12'd0); #1 chk("len unallocated ignored", {20'd0, size_out}, 32'd0);
    size_array = 12'd7;
    #1 chk("size_out out of range", {20'd0, size_out}, 32'd0);
    size_array = 12'd0;
    do_op(0, 1'b1, 12'd0, "len free", aa, ae);
    #1 chk("size kept after free", {20'd0, size_out}, 32'd2);
    do_op(0, 1'b0, 12'd0, "len realloc", aa, ae);
    chk("len realloc handle", {20'd0, aa}, 32'd0);
    #1 chk("size cleared by alloc", {20'd0, size_out}, 32'd0);

    // Contention: both requesters allocate continuously
    do_reset();
    req_free = 2'b00;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      while (ack == 2'b00 && cnt < 6) begin @(negedge clock); cnt++; end
      checks++;
      if (ack == 2'b00) begin
        errors++;
        $display("FAIL rr grant%0d timeout: got no ack expected ack", g);
      end
      chk($sformatf("rr grant%0d", g), {30'd0, ack}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr handle%0d", g), {20'd0, ack_array}, g);
      if (g == 3) req_valid = 2'b00;
      @(negedge clock);
    end
    chk("rr allocs", {20'd0, allocs}, 32'd4);

    // Reset asserted during the ACK cycle
    do_reset();
    size_array = 12'd0;
    do_op(0, 1'b0, 12'd0, "mid alloc0", aa, ae);
    len_upd(12'd0, 12'd0);
    #1 chk("mid size before", {20'd0, size_out}, 32'd1);
    req_free[0] = 1'b0; req_valid[0] = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (ack == 2'b00 && cnt < 6) begin @(negedge clock); cnt++; end
    chk("mid ack before reset", {30'd0, ack}, 32'd1);
    #1 reset = 1'b0;
    #1 chk("mid ack dropped", {30'd0, ack}, 32'd0);
    chk("mid allocs cleared", {20'd0, allocs}, 32'd0);
    chk("mid in_use cleared", {20'd0, in_use}, 32'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_op(0, 1'b0, 12'd0, "mid realloc", aa, ae);
    chk("mid realloc handle", {20'd0, aa}, 32'd0);
    #1 chk("mid size after", {20'd0, size_out}, 32'd0);
    chk("mid allocs after", {20'd0, allocs}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
